// File: rtl/mmio_uart_tx.sv
// MMIO-triggered UART transmitter: edge-detected enqueue into a byte FIFO,
// drained by an 8N1 serialiser with a registered tx line.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            Rst,
    input  logic                            mmio_wea,
    input  logic [31:0]                     mmio_dat,
    input  logic                            clr_ovf,
    output logic                            tx,
    output logic                            tx_busy,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic            wea_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push, push_ok, pop, empty, full, baud_wrap;
    logic [7:0]      head;
    logic            unused_dat;

    assign unused_dat = ^mmio_dat[31:8];

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push      = mmio_wea & ~wea_q;
    // A push into a full FIFO still lands if the same cycle frees a slot.
    assign push_ok   = push & (~full | pop);
    assign head      = mem_q[rd_ptr_q];
    assign baud_wrap = (baud_q == BW'(CLK_DIV - 1));

    // FIFO occupancy and sticky overflow next-state.
    always_comb begin
        count_d = count_q + CW'(push_ok) - CW'(pop);
        ovf_d   = ovf_q;
        if (push & full & ~pop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Transmit FSM next-state: baud timing, shifting and head pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q == S_IDLE) begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!empty) begin
                pop     = 1'b1;
                shift_d = head;
                tx_d    = 1'b0;
                state_d = S_START;
            end
        end else begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
            if (baud_wrap) begin
                case (state_q)
                    S_START: begin
                        tx_d    = shift_q[0];
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                            bit_d   = bit_q + 3'd1;
                        end
                    end
                    S_STOP: begin
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Control state registers; reset aborts any frame and flushes the FIFO.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wea_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wea_q    <= mmio_wea;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= mmio_dat[7:0];
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_empty = empty;
    assign fifo_full  = full;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a tx-line decoder and byte scoreboard.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic        mmio_wea = 1'b0;
    logic [31:0] mmio_dat = '0;
    logic        clr_ovf = 1'b0;
    logic        tx, tx_busy, fifo_empty, fifo_full, overflow;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];
    int starts[$];
    int frames_done = 0;
    int cyc = 0;
    bit mon_active = 0;
    int mon_t = 0;
    logic [7:0] mon_byte;

    mmio_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .Rst(Rst), .mmio_wea(mmio_wea), .mmio_dat(mmio_dat),
        .clr_ovf(clr_ovf), .tx(tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Decode 8N1 frames from tx, sampling mid-bit, and score each byte.
    always @(negedge clk) begin
        cyc++;
        if (!Rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1;
                mon_t = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t == 2) check("start_bit", 32'(tx), 32'd0);
            if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0)
                mon_byte[(mon_t - 6) / 4] = tx;
            if (mon_t == 38) begin
                check("stop_bit", 32'(tx), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                end else begin
                    check("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
                end
                frames_done++;
            end
            if (mon_t == 39) mon_active = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int maxc;
        int nst;
        bit any_low;

        // 1. Reset with random inputs.
        for (int i = 0; i < 6; i++) begin
            mmio_wea = 1'($urandom);
            mmio_dat = $urandom;
            clr_ovf  = 1'($urandom);
            tick();
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(tx_busy), 32'd0);
            check("rst_empty", 32'(fifo_empty), 32'd1);
            check("rst_count", 32'(fifo_count), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
        end
        mmio_wea = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        Rst = 1'b1;
        any_low = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) any_low = 1;
        end
        check("post_rst_quiet", 32'(any_low), 32'd0);

        // 2. Single byte, trigger held high for 3 cycles.
        mmio_dat = 32'h0000_00A5;
        mmio_wea = 1'b1;
        sb.push_back(8'hA5);
        tick();
        check("single_count1", 32'(fifo_count), 32'd1);
        tick();
        check("single_count0", 32'(fifo_count), 32'd0);
        check("single_tx_low", 32'(tx), 32'd0);
        check("single_busy", 32'(tx_busy), 32'd1);
        tick();
        mmio_wea = 1'b0;
        for (int i = 3; i < 41; i++) tick();
        check("single_busy_last", 32'(tx_busy), 32'd1);
        tick();
        check("single_busy_fall", 32'(tx_busy), 32'd0);
        check("single_tx_idle", 32'(tx), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("single_one_frame", 32'(frames_done), 32'd1);

        // 3. Back-to-back frames.
        f0 = frames_done;
        starts.delete();
        maxc = 0;
        for (int i = 0; i < 3; i++) begin
            mmio_dat = 32'(8'h11 * (i + 1));
            sb.push_back(8'(8'h11 * (i + 1)));
            mmio_wea = 1'b1;
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            mmio_wea = 1'b0;
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        for (int i = 0; i < 200 && (frames_done < f0 + 3 || tx_busy); i++) begin
            tick();
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        check("b2b_frames", 32'(frames_done - f0), 32'd3);
        check("b2b_peak", 32'(maxc), 32'd2);
        check("b2b_starts", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check("b2b_gap01", 32'(starts[1] - starts[0]), 32'd40);
            check("b2b_gap12", 32'(starts[2] - starts[1]), 32'd40);
        end

        // 4. Overflow while the first frame is in flight.
        f0 = frames_done;
        mmio_dat = 32'h0000_00C1;
        sb.push_back(8'hC1);
        mmio_wea = 1'b1;
        tick();
        mmio_wea = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            mmio_dat = 32'(8'hA0 + 8'(i));
            if (i < 4) sb.push_back(8'(8'hA0 + 8'(i)));
            mmio_wea = 1'b1;
            tick();
            mmio_wea = 1'b0;
            tick();
        end
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // 5. Push on the exact cycle STOP pops while full.
        for (int i = 16; i < 41; i++) tick();
        check("pre_pop_count", 32'(fifo_count), 32'd4);
        mmio_dat = 32'h0000_005F;
        sb.push_back(8'h5F);
        mmio_wea = 1'b1;
        tick();
        mmio_wea = 1'b0;
        check("simul_count", 32'(fifo_count), 32'd4);
        check("simul_full", 32'(fifo_full), 32'd1);
        check("simul_ovf", 32'(overflow), 32'd0);
        check("simul_tx_start", 32'(tx), 32'd0);
        for (int i = 0; i < 400 && (sb.size() != 0 || tx_busy); i++) tick();
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_frames", 32'(frames_done - f0), 32'd6);
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // 6. Reset during DATA bit 3 with a second byte queued.
        tick();
        mmio_dat = 32'h0000_0035;
        sb.push_back(8'h35);
        mmio_wea = 1'b1;
        tick();
        mmio_wea = 1'b0;
        tick();
        mmio_dat = 32'h0000_0077;
        sb.push_back(8'h77);
        mmio_wea = 1'b1;
        tick();
        mmio_wea = 1'b0;
        for (int i = 3; i < 19; i++) tick();
        check("mid_bit3_low", 32'(tx), 32'd0);
        check("mid_busy", 32'(tx_busy), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_empty", 32'(fifo_empty), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        sb.delete();
        f0 = frames_done;
        tick();
        tick();
        Rst = 1'b1;
        nst = starts.size();
        any_low = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) any_low = 1;
        end
        check("post_mid_quiet", 32'(any_low), 32'd0);
        check("post_mid_frames", 32'(frames_done - f0), 32'd0);
        check("post_mid_starts", 32'(starts.size() - nst), 32'd0);
        check("post_mid_empty", 32'(fifo_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Consumes the memory stage's MMIO outputs (mmio_dat latched by sw to 0xaaaaa008, mmio_wea bit 0 of sw to 0xaaaaa004) and serialises bytes onto a UART TX line. Software writes the data word, then writes 1 to the trigger address. Each 0->1 transition of mmio_wea enqueues mmio_dat[7:0] into a small FIFO, and an 8N1 transmitter drains the FIFO. Sits between the Memory stage and the board-level UART pin.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
FIFO_DEPTH, 16, byte entries in TX FIFO; power of two, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous active-low reset (0 = reset)
mmio_wea  input  1  level trigger from Memory stage; rising edge = enqueue request
mmio_dat  input  32  data word from Memory stage; only [7:0] used
clr_ovf  input  1  synchronous clear of overflow flag
tx  output  1  serial line, idle high
tx_busy  output  1  high whenever FSM is not IDLE
fifo_empty  output  1  FIFO count == 0
fifo_full  output  1  FIFO count == FIFO_DEPTH
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: a push was dropped because FIFO was full

Behaviour:
- Reset (Rst=0, async): tx=1, tx_busy=0, FIFO pointers/count=0 (fifo_empty=1, fifo_full=0), overflow=0, wea_q=0, baud counter=0, bit index=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; queued bytes are discarded.
- Edge detect: wea_q <= mmio_wea each cycle. push = mmio_wea & ~wea_q. Holding mmio_wea high enqueues exactly one byte. mmio_dat[7:0] is sampled on the push edge.
- Push while full, with no pop in the same cycle: the byte is dropped, count is unchanged, and overflow is set.
- Push and pop in the same cycle: both take effect and count is unchanged. This applies even when the FIFO is full; that push is accepted.
- overflow is cleared by clr_ovf=1. If clr_ovf and a dropped push occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, STOP. tx is driven from a register, so there is no combinational path from inputs to tx.
  - IDLE: tx=1. If FIFO is non-empty, pop head into shift register, load baud counter 0, tx<=0, go to START.
  - START: hold tx=0 for CLK_DIV cycles, then tx<=shift[0], bit index=0, go to DATA.
  - DATA: each bit is held CLK_DIV cycles, LSB first. After bit 7's period, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLK_DIV cycles. At the end, if FIFO is non-empty, pop, tx<=0, go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*CLK_DIV cycles from tx falling to the end of stop.
- Latency: if mmio_wea rises and is sampled at edge E (FIFO empty, FSM IDLE), the byte is written at E, popped at E+1, and tx=0 from E+1. fifo_count reads 1 for one cycle only, between E and E+1.
- Baud counter counts 0..CLK_DIV-1 and wraps. Bit transitions happen only at wrap.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. count has one extra bit so that full is distinguishable from empty.
- tx_busy = (state != IDLE). It stays high across back-to-back frames.

Test Plan:
All scenarios use CLK_DIV=4, FIFO_DEPTH=4.
1. Reset: hold Rst=0 with random inputs -> tx=1, tx_busy=0, fifo_empty=1, fifo_count=0, overflow=0. Release reset -> no activity.
2. Single byte: mmio_dat=0x000000A5, pulse mmio_wea high for 3 cycles -> exactly one frame.
   - tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles (40 cycles total).
   - tx_busy falls after the stop bit. Only one frame is sent, since the trigger is level.
3. Back-to-back: push 0x11, 0x22, 0x33 on consecutive rising edges -> three contiguous 40-cycle frames with no idle between them; fifo_count peaks at 2.
4. Overflow: while the first frame is transmitting, push 6 bytes -> 4 accepted (fifo_full=1), extra pushes dropped, overflow=1.
   - The transmitted sequence contains only the accepted bytes.
   - Pulsing clr_ovf clears overflow to 0.
5. Full plus simultaneous pop: FIFO full, push on the exact cycle STOP pops -> push accepted, count stays 4, overflow stays 0.
6. Mid-frame reset: assert Rst=0 during DATA bit 3 -> tx=1 immediately (asynchronous). After release: FSM IDLE, FIFO empty, and no residual frame is sent.
